// File: rtl/hazard_pc_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_pc_ctrl
//   Pipeline control for the 5-stage RISC-V core.
//   - Detects load-use hazards and inserts one stall cycle.
//   - Freezes the whole pipeline while the data memory is busy.
//   - Steers PC redirects on taken branches and jumps.
//   - Flushes IF/ID for SHADOW extra cycles after a redirect, which covers the
//     instruction-memory latency.
//
// Ports
//   clk, reset (async, active-low)
//   id_rs1, id_rs2, id_use_rs1, id_use_rs2 : source operands of the ID instr
//   ex_mem_read, ex_rd                     : load in EX and its destination
//   ex_redirect                            : taken branch/jump resolved in EX
//   mem_busy                               : data memory not ready
//   bubble, pc_redirect                    : PC register / next-PC mux control
//   ifid_hold/flush, idex_hold/flush       : stage-register control
//   exmem_hold                             : holds EX/MEM and MEM/WB
//   stall_cnt                              : saturating count of bubble cycles
//   mem_timeout                            : sticky, busy ran past MAX_WAIT
//
// State   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal flow; load-use stalls and redirects are handled here
// FREEZE  | data memory busy; every stage held
// SHADOW  | redirect issued; IF/ID flushed while fetch catches up
// ---------------------------------------------------------------------------
module hazard_pc_ctrl #(
    parameter int REG_W    = 5,
    parameter int SHADOW   = 1,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             bubble,
    output logic             pc_redirect,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_SHADOW = 2'd2;

    // Nine bits so MAX_WAIT+1 is representable for MAX_WAIT up to 255.
    localparam int               WAIT_W   = 9;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
    localparam logic [1:0]        SH_LOAD  = 2'(SHADOW);
    localparam logic [1:0]        ST_AFTER_REDIR = (SHADOW > 0) ? ST_SHADOW : ST_RUN;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        sh_cnt;
    logic [1:0]        sh_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu_hazard;

    assign lu_hazard = ex_mem_read && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        bubble      = 1'b0;
        pc_redirect = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        state_nxt   = state;
        sh_cnt_nxt  = sh_cnt;

        // Outputs are gated by reset so they drop the moment reset asserts,
        // not at the next clock edge.
        if (reset) begin
            case (state)
                // FREEZE with mem_busy low behaves exactly like RUN, so both
                // states share one decode.
                ST_RUN, ST_FREEZE: begin
                    if (mem_busy) begin
                        bubble     = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_hold  = 1'b1;
                        exmem_hold = 1'b1;
                        state_nxt  = ST_FREEZE;
                    end else if (ex_redirect) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        sh_cnt_nxt  = SH_LOAD;
                        state_nxt   = ST_AFTER_REDIR;
                    end else begin
                        if (lu_hazard) begin
                            bubble     = 1'b1;
                            ifid_hold  = 1'b1;
                            idex_flush = 1'b1;
                        end
                        state_nxt = ST_RUN;
                    end
                end
                ST_SHADOW: begin
                    // ID holds a flushed NOP here, so lu_hazard is irrelevant.
                    if (mem_busy) begin
                        bubble     = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_hold  = 1'b1;
                        exmem_hold = 1'b1;
                    end else if (ex_redirect) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        sh_cnt_nxt  = SH_LOAD;
                    end else begin
                        ifid_flush = 1'b1;
                        sh_cnt_nxt = sh_cnt - 2'd1;
                        if (sh_cnt <= 2'd1) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            sh_cnt      <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state  <= state_nxt;
            sh_cnt <= sh_cnt_nxt;

            // The first busy cycle (seen while still in RUN) counts as well.
            if (mem_busy) begin
                if (wait_cnt != WAIT_SAT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= WAIT_LIM) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (bubble && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
